// File: rtl/axis_pkt_queue_if.sv
// AXI4-Stream beat bundle shared by the ingress and egress sides of the packet queue.
interface axis_pkt_queue_if #(
    parameter int DATA_WIDTH = 8,
    parameter int MTY_WIDTH  = 8
);
    logic                  tvalid;
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tlast;
    logic [MTY_WIDTH-1:0]  tuser_mty;
    logic                  tready;

    modport master (output tvalid, output tdata, output tlast, output tuser_mty, input tready);
    modport slave  (input tvalid, input tdata, input tlast, input tuser_mty, output tready);
endinterface

// File: rtl/axis_pkt_queue.sv
// axis_pkt_queue: store-and-forward AXI4-Stream packet queue. Packets become
// visible to the egress side only once their tlast beat commits; a partial
// packet can be rolled back by an external drop or by an internal overflow
// (one packet larger than the whole memory).
module axis_pkt_queue #(
    parameter int DATA_WIDTH = 8,
    parameter int MTY_WIDTH  = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 aclk,
    input  logic                 areset,
    axis_pkt_queue_if.slave      s_axis,
    input  logic                 drop_incmpt_pkt,
    axis_pkt_queue_if.master     m_axis,
    output logic [ADDR_WIDTH:0]  pkt_count,
    output logic [CNT_WIDTH-1:0] drop_count,
    output logic                 overflow
);
    localparam int DEPTH   = 1 << ADDR_WIDTH;
    localparam int ENTRY_W = DATA_WIDTH + MTY_WIDTH + 1;

    typedef logic [ADDR_WIDTH:0] ptr_t;
    localparam ptr_t PTR_ONE   = ptr_t'(1);
    localparam ptr_t DEPTH_PTR = ptr_t'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FILL    = 2'd1,
        ST_DISCARD = 2'd2
    } wr_state_t;

    logic [ENTRY_W-1:0]    mem_r [DEPTH];
    ptr_t                  wr_ptr_r, wr_commit_r, rd_ptr_r;
    wr_state_t             state_r;
    logic                  s_ready_r;
    logic                  out_valid_r, out_last_r;
    logic [DATA_WIDTH-1:0] out_data_r;
    logic [MTY_WIDTH-1:0]  out_mty_r;
    logic [ADDR_WIDTH:0]   pkt_count_r;
    logic [CNT_WIDTH-1:0]  drop_count_r;
    logic                  overflow_r;

    ptr_t                  wr_ptr_nxt_s, wr_commit_nxt_s, rd_ptr_nxt_s;
    ptr_t                  wr_adv_s, fill_after_s, occ_nxt_s;
    wr_state_t             state_nxt_s;
    logic                  accept_s, load_s, pop_last_s, uncommitted_full_s;
    logic                  mem_we_s, commit_s, drop_inc_s, ovf_s, ready_nxt_s;
    logic [ENTRY_W-1:0]    wr_entry_s, rd_entry_s;

    assign accept_s   = s_axis.tvalid & s_ready_r;
    assign wr_entry_s = {s_axis.tlast, s_axis.tuser_mty, s_axis.tdata};
    assign rd_entry_s = mem_r[rd_ptr_r[ADDR_WIDTH-1:0]];

    // Read side: refill the output register from committed entries only
    always_comb begin
        pop_last_s = out_valid_r & m_axis.tready & out_last_r;
        if (((!out_valid_r) || m_axis.tready) && (rd_ptr_r != wr_commit_r)) begin
            load_s       = 1'b1;
            rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
        end else begin
            load_s       = 1'b0;
            rd_ptr_nxt_s = rd_ptr_r;
        end
    end

    // Detect a single uncommitted packet occupying the entire memory after this edge
    always_comb begin
        if (accept_s) begin
            wr_adv_s = wr_ptr_r + PTR_ONE;
        end else begin
            wr_adv_s = wr_ptr_r;
        end
        fill_after_s       = wr_adv_s - rd_ptr_nxt_s;
        uncommitted_full_s = (fill_after_s == DEPTH_PTR) && (rd_ptr_nxt_s == wr_commit_r);
    end

    // Write-side next state: drop rollback beats commit, overflow rollback, discard sink
    always_comb begin
        state_nxt_s     = state_r;
        wr_ptr_nxt_s    = wr_ptr_r;
        wr_commit_nxt_s = wr_commit_r;
        mem_we_s        = 1'b0;
        commit_s        = 1'b0;
        drop_inc_s      = 1'b0;
        ovf_s           = 1'b0;
        if (drop_incmpt_pkt) begin
            wr_ptr_nxt_s = wr_commit_r;
            state_nxt_s  = ST_IDLE;
            // Beats sunk in DISCARD were already counted by the overflow
            if ((wr_ptr_r != wr_commit_r) || (accept_s && (state_r != ST_DISCARD))) begin
                drop_inc_s = 1'b1;
            end else begin
                drop_inc_s = 1'b0;
            end
        end else begin
            case (state_r)
                ST_DISCARD: begin
                    if (accept_s && s_axis.tlast) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_DISCARD;
                    end
                end
                ST_IDLE, ST_FILL: begin
                    if (accept_s && s_axis.tlast) begin
                        mem_we_s        = 1'b1;
                        wr_ptr_nxt_s    = wr_ptr_r + PTR_ONE;
                        wr_commit_nxt_s = wr_ptr_r + PTR_ONE;
                        state_nxt_s     = ST_IDLE;
                        commit_s        = 1'b1;
                    end else if (uncommitted_full_s) begin
                        wr_ptr_nxt_s = wr_commit_r;
                        state_nxt_s  = ST_DISCARD;
                        ovf_s        = 1'b1;
                        drop_inc_s   = 1'b1;
                    end else if (accept_s) begin
                        mem_we_s     = 1'b1;
                        wr_ptr_nxt_s = wr_adv_s;
                        state_nxt_s  = ST_FILL;
                    end else begin
                        state_nxt_s = state_r;
                    end
                end
                default: begin
                    state_nxt_s  = ST_IDLE;
                    wr_ptr_nxt_s = wr_commit_r;
                end
            endcase
        end
        occ_nxt_s   = wr_ptr_nxt_s - rd_ptr_nxt_s;
        ready_nxt_s = (state_nxt_s == ST_DISCARD) || (occ_nxt_s < DEPTH_PTR);
    end

    // Pointer, write-state, ingress ready and status counters
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wr_ptr_r     <= {(ADDR_WIDTH+1){1'b0}};
            wr_commit_r  <= {(ADDR_WIDTH+1){1'b0}};
            rd_ptr_r     <= {(ADDR_WIDTH+1){1'b0}};
            state_r      <= ST_IDLE;
            s_ready_r    <= 1'b0;
            pkt_count_r  <= {(ADDR_WIDTH+1){1'b0}};
            drop_count_r <= {CNT_WIDTH{1'b0}};
            overflow_r   <= 1'b0;
        end else begin
            wr_ptr_r    <= wr_ptr_nxt_s;
            wr_commit_r <= wr_commit_nxt_s;
            rd_ptr_r    <= rd_ptr_nxt_s;
            state_r     <= state_nxt_s;
            s_ready_r   <= ready_nxt_s;
            overflow_r  <= ovf_s;
            case ({commit_s, pop_last_s})
                2'b10:   pkt_count_r <= pkt_count_r + {{ADDR_WIDTH{1'b0}}, 1'b1};
                2'b01:   pkt_count_r <= pkt_count_r - {{ADDR_WIDTH{1'b0}}, 1'b1};
                default: pkt_count_r <= pkt_count_r;
            endcase
            if (drop_inc_s && (drop_count_r != {CNT_WIDTH{1'b1}})) begin
                drop_count_r <= drop_count_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end else begin
                drop_count_r <= drop_count_r;
            end
        end
    end

    // Beat storage; contents need no reset since pointers gate every read
    always_ff @(posedge aclk) begin
        if (mem_we_s) begin
            mem_r[wr_ptr_r[ADDR_WIDTH-1:0]] <= wr_entry_s;
        end
    end

    // Egress output register, held stable while stalled
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            out_mty_r   <= {MTY_WIDTH{1'b0}};
            out_data_r  <= {DATA_WIDTH{1'b0}};
        end else if (load_s) begin
            out_valid_r <= 1'b1;
            out_last_r  <= rd_entry_s[ENTRY_W-1];
            out_mty_r   <= rd_entry_s[DATA_WIDTH +: MTY_WIDTH];
            out_data_r  <= rd_entry_s[DATA_WIDTH-1:0];
        end else if (m_axis.tready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    assign s_axis.tready    = s_ready_r;
    assign m_axis.tvalid    = out_valid_r;
    assign m_axis.tdata     = out_data_r;
    assign m_axis.tlast     = out_last_r;
    assign m_axis.tuser_mty = out_mty_r;
    assign pkt_count        = pkt_count_r;
    assign drop_count       = drop_count_r;
    assign overflow         = overflow_r;
endmodule
